writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Writeback stage of the pipelined Y86-64 core: the write side of the register-file interface whose read side is the decode stage.
- Holds the W pipeline register, fed from the memory stage.
- Commits valE/valM to the 15-entry register file through ports E and M.
- Serves the decode stage's srcA/srcB reads and drives the processor status.

Parameters:
- WIDTH, 64, data width of registers and valE/valM.
- NREG, 15, number of architectural registers (IDs 0..14); ID 4'hF = RNONE.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- m_stat  in  4  memory-stage status (1=AOK, 2=HLT, 3=ADR, 4=INS).
- m_icode  in  4  memory-stage instruction code.
- m_dstE  in  4  destination register for valE (F = none).
- m_dstM  in  4  destination register for valM (F = none).
- m_valE  in  WIDTH  ALU result.
- m_valM  in  WIDTH  memory read data.
- W_stall  in  1  hold W register contents.
- W_bubble  in  1  load nop bubble into W register.
- srcA  in  4  decode read address A (F = none).
- srcB  in  4  decode read address B (F = none).
- rvalA  out  WIDTH  register-file data at srcA; 0 when srcA=F.
- rvalB  out  WIDTH  register-file data at srcB; 0 when srcB=F.
- W_icode  out  4  icode held in W register.
- W_dstE  out  4  dstE held in W (used for forwarding).
- W_dstM  out  4  dstM held in W.
- W_valE  out  WIDTH  valE held in W.
- W_valM  out  WIDTH  valM held in W.
- stat  out  4  processor status = W_stat.
- halted  out  1  sticky stop flag.

Behaviour:
- Reset (synchronous, highest priority):
  - All 15 registers = 0.
  - W register = bubble: icode=1 (nop), dstE=dstM=F, valE=valM=0, stat=AOK.
  - halted=0.
  - Reset asserted mid-operation or while halted clears everything on that edge; no register write occurs on a reset edge.
- W register update, each non-reset edge, when halted=0:
  - W_stall=1: hold. W_stall has priority over W_bubble when both are asserted.
  - Else W_bubble=1: load bubble.
  - Else: capture all m_* inputs.
- Register write, each non-reset edge, when halted=0 and W_stat=AOK:
  - Port E: if W_dstE != F, reg[W_dstE] <= W_valE.
  - Port M: if W_dstM != F, reg[W_dstM] <= W_valM.
  - If W_dstE == W_dstM != F, port M wins.
  - Writes come from W contents, so they happen regardless of W_stall; a stalled W entry is re-written each cycle, which is idempotent.
- Halt:
  - On a non-reset edge with halted=0 and W_stat != AOK, set halted=1.
  - That instruction does not write.
  - While halted=1: W register frozen, no writes, stat holds the faulting code.
- Latency:
  - m_* sampled at edge N enters W.
  - Register updated at edge N+1.
  - rvalA/rvalB reflect the new value combinationally after edge N+1.
- Reads:
  - Combinational, from current array state; no write-through bypass (decode forwarding covers that cycle).
  - srcA/srcB = F yields 0.
  - IDs 0..14 valid.
- Unused icode values are not decoded here; only stat/dst fields gate writes.

Test Plan:
1. Reset, then m_dstE=2, m_valE=0x2A382812, m_dstM=F, stat=AOK -> W_dstE=2 after edge 1; rvalA (srcA=2) = 0x2A382812 after edge 2; other registers 0.
2. W_dstE=W_dstM=7, valE=0x11, valM=0x22 -> reg7 = 0x22 (port M wins).
3. W_stall=1 for 3 cycles, with m_* changing to dstE=3/valE=0x55 -> W outputs unchanged; reg3 stays 0 until the stall drops; W_bubble=1 with W_stall=1 -> hold.
4. W_bubble=1 with m_dstE=5 -> W_icode=1, W_dstE=F; reg5 unchanged.
5. m_stat=3 (ADR), dstE=4, valE=0x99 -> after W capture, the next edge sets halted=1; stat=3; reg4 stays 0; later AOK inputs ignored, W frozen.
6. Reset asserted while halted and in the same cycle as a pending write to reg1 -> halted=0, stat=1, reg1=0, W = bubble.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: W pipeline register, 15-entry register file with
// two write ports (E, M), two combinational read ports, and the sticky halt flag.
module writeback_regfile #(
    parameter int WIDTH = 64,
    parameter int NREG  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic [WIDTH-1:0] m_valE,
    input  logic [WIDTH-1:0] m_valM,
    input  logic             W_stall,
    input  logic             W_bubble,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] rvalA,
    output logic [WIDTH-1:0] rvalB,
    output logic [3:0]       W_icode,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [WIDTH-1:0] W_valE,
    output logic [WIDTH-1:0] W_valM,
    output logic [3:0]       stat,
    output logic             halted
);
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] I_NOP    = 4'd1;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [3:0]       r_W_stat;
    logic [3:0]       r_W_icode;
    logic [3:0]       r_W_dstE;
    logic [3:0]       r_W_dstM;
    logic [WIDTH-1:0] r_W_valE;
    logic [WIDTH-1:0] r_W_valM;
    logic             r_halted;

    logic w_ok;
    assign w_ok = (r_W_stat == STAT_AOK);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_W_stat  <= STAT_AOK;
            r_W_icode <= I_NOP;
            r_W_dstE  <= RNONE;
            r_W_dstM  <= RNONE;
            r_W_valE  <= '0;
            r_W_valM  <= '0;
            r_halted  <= 1'b0;
        end else if (!r_halted) begin
            if (!w_ok) begin
                // Faulting entry stays in W so stat keeps reporting its code.
                r_halted <= 1'b1;
            end else begin
                // Port M is assigned last so it wins when both target one register.
                if (r_W_dstE != RNONE) r_regs[r_W_dstE] <= r_W_valE;
                if (r_W_dstM != RNONE) r_regs[r_W_dstM] <= r_W_valM;
                if (!W_stall) begin
                    if (W_bubble) begin
                        r_W_stat  <= STAT_AOK;
                        r_W_icode <= I_NOP;
                        r_W_dstE  <= RNONE;
                        r_W_dstM  <= RNONE;
                        r_W_valE  <= '0;
                        r_W_valM  <= '0;
                    end else begin
                        r_W_stat  <= m_stat;
                        r_W_icode <= m_icode;
                        r_W_dstE  <= m_dstE;
                        r_W_dstM  <= m_dstM;
                        r_W_valE  <= m_valE;
                        r_W_valM  <= m_valM;
                    end
                end
            end
        end
    end

    // Reads see array state only; same-cycle writes are covered by decode forwarding.
    assign rvalA   = (srcA == RNONE) ? '0 : r_regs[srcA];
    assign rvalB   = (srcB == RNONE) ? '0 : r_regs[srcB];
    assign W_icode = r_W_icode;
    assign W_dstE  = r_W_dstE;
    assign W_dstM  = r_W_dstM;
    assign W_valE  = r_W_valE;
    assign W_valM  = r_W_valM;
    assign stat    = r_W_stat;
    assign halted  = r_halted;
endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: scenario tasks with a queue of
// expected register-file contents checked through the read ports.
module tb_writeback_regfile;
    localparam int WIDTH = 64;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       m_stat, m_icode, m_dstE, m_dstM;
    logic [WIDTH-1:0] m_valE, m_valM;
    logic             W_stall, W_bubble;
    logic [3:0]       srcA, srcB;
    logic [WIDTH-1:0] rvalA, rvalB;
    logic [3:0]       W_icode, W_dstE, W_dstM, stat;
    logic [WIDTH-1:0] W_valE, W_valM;
    logic             halted;

    typedef struct {
        logic [3:0]       id;
        logic [WIDTH-1:0] val;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    writeback_regfile #(.WIDTH(WIDTH), .NREG(15)) dut (
        .clock(clock), .reset(reset),
        .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .m_valE(m_valE), .m_valM(m_valM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
        .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM), .stat(stat), .halted(halted)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_m(input logic [3:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [WIDTH-1:0] ve, input logic [WIDTH-1:0] vm);
        m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm;
        m_valE = ve; m_valM = vm;
    endtask

    task automatic set_idle();
        set_m(4'd1, 4'd1, 4'hF, 4'hF, '0, '0);
    endtask

    // Pop the oldest expectation and compare it against the register file.
    task automatic sb_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            srcA = e.id;
            #1;
            if (rvalA !== e.val) begin
                errors++;
                $display("FAIL %s: reg%0d got %h expected %h", name, e.id, rvalA, e.val);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        srcA = 4'hF; srcB = 4'hF;
        set_m(4'd1, 4'd3, 4'd9, 4'd10, 64'hDEAD, 64'hBEEF);
        step();
        step();
        reset = 1'b0;
        set_idle();
        checks++;
        if (W_icode !== 4'd1 || W_dstE !== 4'hF || W_dstM !== 4'hF ||
            W_valE !== '0 || W_valM !== '0) begin
            errors++;
            $display("FAIL reset_w: icode %h dstE %h dstM %h valE %h valM %h expected 1 f f 0 0",
                     W_icode, W_dstE, W_dstM, W_valE, W_valM);
        end
        checks++;
        if (stat !== 4'd1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_stat: stat %h halted %b expected 1 0", stat, halted);
        end
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i); srcB = 4'(14 - i);
            #1;
            checks++;
            if (rvalA !== '0 || rvalB !== '0) begin
                errors++;
                $display("FAIL reset_regs: idx %0d rvalA %h rvalB %h expected 0", i, rvalA, rvalB);
            end
        end
        srcA = 4'hF; srcB = 4'hF;
        #1;
        checks++;
        if (rvalA !== '0 || rvalB !== '0) begin
            errors++;
            $display("FAIL rnone_read: rvalA %h rvalB %h expected 0", rvalA, rvalB);
        end
    endtask

    task automatic test_basic_write();
        set_m(4'd1, 4'd3, 4'd2, 4'hF, 64'h2A382812, 64'h0);
        sb.push_back('{id: 4'd2, val: 64'h2A382812});
        step();
        set_idle();
        srcA = 4'd2;
        #1;
        checks++;
        if (W_dstE !== 4'd2 || W_valE !== 64'h2A382812) begin
            errors++;
            $display("FAIL w_capture: dstE %h valE %h expected 2 2a382812", W_dstE, W_valE);
        end
        checks++;
        if (rvalA !== '0) begin
            errors++;
            $display("FAIL no_bypass: rvalA %h expected 0", rvalA);
        end
        step();
        sb_check("basic_write");
        srcB = 4'd3;
        #1;
        checks++;
        if (rvalB !== '0) begin
            errors++;
            $display("FAIL other_reg: reg3 %h expected 0", rvalB);
        end
        srcB = 4'hF;
    endtask

    task automatic test_port_m_wins();
        set_m(4'd1, 4'd5, 4'd7, 4'd7, 64'h11, 64'h22);
        sb.push_back('{id: 4'd7, val: 64'h22});
        step();
        set_idle();
        step();
        sb_check("port_m_wins");
    endtask

    task automatic test_stall();
        set_m(4'd1, 4'd3, 4'd6, 4'hF, 64'h66, 64'h0);
        sb.push_back('{id: 4'd6, val: 64'h66});
        step();
        W_stall = 1'b1;
        set_m(4'd1, 4'd3, 4'd3, 4'hF, 64'h55, 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            srcA = 4'd3;
            #1;
            checks++;
            if (W_dstE !== 4'd6 || W_valE !== 64'h66 || rvalA !== '0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d dstE %h valE %h reg3 %h expected 6 66 0",
                         c, W_dstE, W_valE, rvalA);
            end
        end
        sb_check("stall_rewrite");
        W_bubble = 1'b1;
        step();
        checks++;
        if (W_dstE !== 4'd6 || W_icode !== 4'd3) begin
            errors++;
            $display("FAIL stall_over_bubble: dstE %h icode %h expected 6 3", W_dstE, W_icode);
        end
        W_stall = 1'b0; W_bubble = 1'b0;
        sb.push_back('{id: 4'd3, val: 64'h55});
        step();
        set_idle();
        srcA = 4'd3;
        #1;
        checks++;
        if (W_dstE !== 4'd3 || rvalA !== '0) begin
            errors++;
            $display("FAIL stall_release: dstE %h reg3 %h expected 3 0", W_dstE, rvalA);
        end
        step();
        sb_check("stall_release_write");
    endtask

    task automatic test_bubble();
        W_bubble = 1'b1;
        set_m(4'd1, 4'd3, 4'd5, 4'hF, 64'h77, 64'h0);
        step();
        W_bubble = 1'b0;
        set_idle();
        checks++;
        if (W_icode !== 4'd1 || W_dstE !== 4'hF) begin
            errors++;
            $display("FAIL bubble_load: icode %h dstE %h expected 1 f", W_icode, W_dstE);
        end
        step();
        srcA = 4'd5;
        #1;
        checks++;
        if (rvalA !== '0) begin
            errors++;
            $display("FAIL bubble_nowrite: reg5 %h expected 0", rvalA);
        end
    endtask

    task automatic test_halt();
        set_m(4'd3, 4'd5, 4'd4, 4'hF, 64'h99, 64'h0);
        step();
        set_idle();
        checks++;
        if (stat !== 4'd3 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_capture: stat %h halted %b expected 3 0", stat, halted);
        end
        step();
        set_m(4'd1, 4'd3, 4'd8, 4'hF, 64'hAA, 64'h0);
        srcA = 4'd4;
        #1;
        checks++;
        if (halted !== 1'b1 || stat !== 4'd3 || rvalA !== '0) begin
            errors++;
            $display("FAIL halt_set: halted %b stat %h reg4 %h expected 1 3 0", halted, stat, rvalA);
        end
        for (int c = 0; c < 3; c++) step();
        srcA = 4'd8;
        #1;
        checks++;
        if (W_dstE !== 4'd4 || halted !== 1'b1 || stat !== 4'd3 || rvalA !== '0) begin
            errors++;
            $display("FAIL halt_frozen: dstE %h halted %b stat %h reg8 %h expected 4 1 3 0",
                     W_dstE, halted, stat, rvalA);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        set_idle();
        step();
        reset = 1'b0;
        checks++;
        if (halted !== 1'b0 || stat !== 4'd1 || W_dstE !== 4'hF) begin
            errors++;
            $display("FAIL reset_halted: halted %b stat %h dstE %h expected 0 1 f", halted, stat, W_dstE);
        end
        set_m(4'd1, 4'd3, 4'd1, 4'hF, 64'hBB, 64'h0);
        step();
        reset = 1'b1;
        set_idle();
        step();
        reset = 1'b0;
        srcA = 4'd1; srcB = 4'd7;
        #1;
        checks++;
        if (rvalA !== '0 || rvalB !== '0 || W_icode !== 4'd1 || W_dstE !== 4'hF ||
            W_valE !== '0 || halted !== 1'b0 || stat !== 4'd1) begin
            errors++;
            $display("FAIL reset_pending: reg1 %h reg7 %h icode %h dstE %h valE %h halted %b stat %h",
                     rvalA, rvalB, W_icode, W_dstE, W_valE, halted, stat);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_port_m_wins();
        test_stall();
        test_bubble();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
